nxn_game_controller: RTL

Parametrised successor to the 3×3 tic-tac-toe game controller. Sequences an N×N board game between two players, validates moves against its own occupancy map, writes accepted moves to the external board memory, detects a full board (draw), and enforces an optional per-turn timeout. Sits between the player input logic and the board RAM/win checker. `gameIsDone` comes from an external win checker that reads the board RAM.

---
 rtl/nxn_game_controller_if.sv | 41 ++++
 rtl/nxn_game_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nxn_game_controller_if.sv
// Purpose: groups the game controller's player-side and board-side signals.
// Latency: none; pure wiring bundle.
// Backpressure: none; strobes are single-cycle with no ready path.
interface nxn_game_controller_if #(
    parameter int N = 3
);
    localparam int CELLS = N * N;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);

    // Player and win-checker side.
    logic          newGame;
    logic          isPlayer1Start;
    logic          playerWrite;
    logic [AW-1:0] playerInput;
    logic          gameIsDone;

    // Board RAM and status side.
    logic [AW-1:0] addr;
    logic [1:0]    cellState;
    logic          cellWrite;
    logic [2:0]    outputState;
    logic          moveRejected;
    logic          timedOut;
    logic [CW-1:0] moveCount;
    logic [1:0]    winner;

    // Player logic / environment side.
    modport master (
        output newGame, isPlayer1Start, playerWrite, playerInput, gameIsDone,
        input  addr, cellState, cellWrite, outputState, moveRejected,
               timedOut, moveCount, winner
    );

    // Controller side.
    modport slave (
        input  newGame, isPlayer1Start, playerWrite, playerInput, gameIsDone,
        output addr, cellState, cellWrite, outputState, moveRejected,
               timedOut, moveCount, winner
    );
endinterface

// File: rtl/nxn_game_controller.sv
// Purpose: sequences an NxN two-player game: board clear, move validation, draw and turn timeout.
// Latency: one cycle from playerWrite/newGame/gameIsDone to every registered output.
// Backpressure: none; illegal moves pulse moveRejected, idle turns forfeit after TIMEOUT cycles.
module nxn_game_controller #(
    parameter int N       = 3,
    parameter int TIMEOUT = 0
) (
    input logic                  ph1,
    input logic                  reset,
    nxn_game_controller_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // Address bound is one bit wider so CELLS = 2**AW does not wrap to zero.
    localparam logic [AW:0]   CELLS_X = (AW + 1)'(CELLS);
    localparam logic [AW-1:0] LAST    = AW'(CELLS - 1);
    localparam logic [CW-1:0] FULL    = CW'(CELLS);
    localparam logic [TW-1:0] TLIM    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          TO_EN   = (TIMEOUT > 0);

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] MARK_X = 2'b10;
    localparam logic [1:0] MARK_O = 2'b11;

    typedef enum logic [2:0] {
        S_START = 3'b000,
        S_P1    = 3'b001,
        S_P2    = 3'b010,
        S_END   = 3'b011
    } state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  sweep_q, sweep_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [1:0]     cell_q, cell_d;
    logic           cw_q, cw_d;
    logic           rej_q, rej_d;
    logic           to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     win_q, win_d;
    logic [CELLS-1:0] occ_q, occ_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic           in_range;
    logic           legal;
    logic [1:0]     mark;
    state_t         other;

    assign in_range = ({1'b0, bus.playerInput} < CELLS_X);
    assign legal    = in_range && !occ_q[bus.playerInput];
    assign mark     = (state == S_P2) ? MARK_O : MARK_X;
    assign other    = (state == S_P1) ? S_P2 : S_P1;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt = state;
        sweep_d   = sweep_q;
        addr_d    = addr_q;
        cell_d    = cell_q;
        cw_d      = 1'b0;
        rej_d     = 1'b0;
        to_d      = 1'b0;
        cnt_d     = cnt_q;
        win_d     = win_q;
        occ_d     = occ_q;
        tmr_d     = tmr_q;

        if (bus.newGame) begin
            state_nxt = S_START;
            sweep_d   = '0;
            addr_d    = '0;
            cell_d    = EMPTY;
            cnt_d     = '0;
            win_d     = EMPTY;
            occ_d     = '0;
            tmr_d     = '0;
        end else begin
            case (state)
                S_START: begin
                    addr_d = sweep_q;
                    cell_d = EMPTY;
                    cw_d   = 1'b1;
                    occ_d  = '0;
                    cnt_d  = '0;
                    win_d  = EMPTY;
                    tmr_d  = '0;
                    if (sweep_q == LAST) begin
                        sweep_d   = '0;
                        state_nxt = bus.isPlayer1Start ? S_P1 : S_P2;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
                S_P1, S_P2: begin
                    if (bus.gameIsDone) begin
                        // cell_q still holds the mark of the last accepted move.
                        state_nxt = S_END;
                        win_d     = cell_q;
                    end else if (cnt_q == FULL) begin
                        state_nxt = S_END;
                        win_d     = EMPTY;
                    end else if (bus.playerWrite && legal) begin
                        addr_d                 = bus.playerInput;
                        cell_d                 = mark;
                        cw_d                   = 1'b1;
                        occ_d[bus.playerInput] = 1'b1;
                        cnt_d                  = cnt_q + 1'b1;
                        state_nxt              = other;
                        tmr_d                  = '0;
                    end else if (bus.playerWrite) begin
                        // A rejected move keeps the turn clock running.
                        rej_d = 1'b1;
                        if (tmr_q != TLIM) begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end else if (TO_EN && (tmr_q == TLIM)) begin
                        to_d      = 1'b1;
                        state_nxt = other;
                        tmr_d     = '0;
                    end else if (tmr_q != TLIM) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_END: begin
                    // Hold everything; strobes already default to zero.
                end
                default: begin
                    state_nxt = S_START;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            sweep_q <= '0;
            addr_q  <= '0;
            cell_q  <= EMPTY;
            cw_q    <= 1'b0;
            rej_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            win_q   <= EMPTY;
            occ_q   <= '0;
            tmr_q   <= '0;
        end else begin
            sweep_q <= sweep_d;
            addr_q  <= addr_d;
            cell_q  <= cell_d;
            cw_q    <= cw_d;
            rej_q   <= rej_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            occ_q   <= occ_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.addr         = addr_q;
    assign bus.cellState    = cell_q;
    assign bus.cellWrite    = cw_q;
    assign bus.outputState  = state;
    assign bus.moveRejected = rej_q;
    assign bus.timedOut     = to_q;
    assign bus.moveCount    = cnt_q;
    assign bus.winner       = win_q;
endmodule
